// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle add/logic/shift ops plus iterative multiply and
// restoring divide that write the HI/LO pair, with a valid/ready issue handshake.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         cmd,
  input  logic [WIDTH-1:0]   val1,
  input  logic [WIDTH-1:0]   val2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               div_by_zero,
  output logic               busy
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_wh, r_wl, r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_neg, r_out_valid, r_dbz;

  logic [WIDTH-1:0]   w_alu;
  logic               w_is_mult, w_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub, w_div_hi, w_div_lo;
  logic               w_qbit, w_last;

  always_comb begin
    w_alu = '0;
    case (cmd)
      4'd0:    w_alu = val1 + val2;
      4'd1:    w_alu = val1 - val2;
      4'd2:    w_alu = val1 & val2;
      4'd3:    w_alu = val1 | val2;
      4'd4:    w_alu = ~(val1 | val2);
      4'd5:    w_alu = val1 ^ val2;
      4'd6:    w_alu = val1 << shamt;
      4'd7:    w_alu = val1 >> shamt;
      4'd8:    w_alu = $signed(val1) >>> shamt;
      4'd12:   w_alu = r_hi;
      4'd13:   w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; -2^(W-1) maps onto its W-bit unsigned magnitude.
  assign w_is_mult = (cmd == 4'd10);
  assign w_mag_a   = (w_is_mult && val1[WIDTH-1]) ? -val1 : val1;
  assign w_mag_b   = (w_is_mult && val2[WIDTH-1]) ? -val2 : val2;
  assign w_neg     = w_is_mult && (val1[WIDTH-1] ^ val2[WIDTH-1]);

  // Shift-add step: r_wh is the running high half, r_wl shifts the multiplier out.
  assign w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_wl[WIDTH-1:1]};
  assign w_prod    = r_neg ? -{w_mul_hi, w_mul_lo} : {w_mul_hi, w_mul_lo};

  // Restoring step: r_wh is the partial remainder, r_wl shifts dividend out and quotient in.
  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  assign w_rem_sh  = {r_wh, r_wl[WIDTH-1]};
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_qbit    = (w_rem_sh >= {1'b0, r_b});
  assign w_div_hi  = w_qbit ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_div_lo  = {r_wl[WIDTH-2:0], w_qbit};

  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_wh        <= '0;
      r_wl        <= '0;
      r_b         <= '0;
      r_neg       <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            r_cnt <= '0;
            if (cmd == 4'd9 || cmd == 4'd10) begin
              r_state <= S_MUL;
              r_wh    <= '0;
              r_wl    <= w_mag_a;
              r_b     <= w_mag_b;
              r_neg   <= w_neg;
            end else if (cmd == 4'd11) begin
              r_state <= S_DIV;
              r_wh    <= '0;
              r_wl    <= val1;
              r_b     <= val2;
              r_neg   <= 1'b0;
            end else begin
              r_result    <= w_alu;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_wh  <= w_mul_hi;
            r_wl  <= w_mul_lo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state     <= S_IDLE;
              r_hi        <= w_prod[2*WIDTH-1:WIDTH];
              r_lo        <= w_prod[WIDTH-1:0];
              r_result    <= w_prod[WIDTH-1:0];
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_wh  <= w_div_hi;
            r_wl  <= w_div_lo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state     <= S_IDLE;
              r_hi        <= w_div_hi;
              r_lo        <= w_div_lo;
              r_result    <= w_div_lo;
              r_out_valid <= 1'b1;
              r_dbz       <= (r_b == '0);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: transaction-level reference model checked every cycle,
// plus literal expectations from hand-worked vectors.
module tb_seq_alu;
  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cmd;
  logic [W-1:0]  val1, val2;
  logic [4:0]    shamt;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          div_by_zero;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  seq_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd),
    .val1(val1), .val2(val2), .shamt(shamt), .flush(flush), .out_valid(out_valid),
    .result(result), .div_by_zero(div_by_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic [31:0] hi, input logic [31:0] lo);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return ~(a | b);
      4'd5:    return a ^ b;
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return $signed(a) >>> sh;
      4'd12:   return hi;
      4'd13:   return lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [64:0] model_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    return {1'b0, a % b, a / b};
  endfunction

  // Reference model: results of long ops are computed at acceptance and released W edges later.
  int           m_left;
  logic [31:0]  m_hi, m_lo, m_res, m_pend_hi, m_pend_lo;
  logic         m_ov, m_dbz, m_pend_dbz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0; m_res <= '0; m_ov <= 1'b0; m_dbz <= 1'b0;
      m_pend_hi <= '0; m_pend_lo <= '0; m_pend_dbz <= 1'b0;
    end else begin
      m_ov  <= 1'b0;
      m_dbz <= 1'b0;
      if (m_left != 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= m_pend_hi; m_lo <= m_pend_lo; m_res <= m_pend_lo;
            m_ov <= 1'b1; m_dbz <= m_pend_dbz;
          end
        end
      end else if (in_valid && !flush) begin
        if (cmd == 4'd9 || cmd == 4'd10) begin
          {m_pend_hi, m_pend_lo} <= model_mul(cmd == 4'd10, val1, val2);
          m_pend_dbz <= 1'b0;
          m_left <= W;
        end else if (cmd == 4'd11) begin
          {m_pend_dbz, m_pend_hi, m_pend_lo} <= model_div(val1, val2);
          m_left <= W;
        end else begin
          m_res <= model_alu(cmd, val1, val2, shamt, m_hi, m_lo);
          m_ov  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("in_ready", 64'(in_ready), 64'(m_left == 0));
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    if (m_ov) chk("result", 64'(result), 64'(m_res));
    if (out_valid) pulses++;
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_wait", 64'(in_ready), 64'd1);
    cmd = c; val1 = a; val2 = b; shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic op1(input string name, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    issue(c, a, b, sh);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk(name, 64'(result), 64'(exp));
  endtask

  task automatic wait_done(output int n, output int low);
    n = 0; low = 0;
    while (!out_valid && n < 200) begin
      if (!in_ready) low++;
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int n, low, p0;
    rst = 1'b0; in_valid = 1'b0; cmd = '0; val1 = '0; val2 = '0; shamt = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    op1("sra", 4'd8, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000);
    op1("srl", 4'd7, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000);
    op1("sll", 4'd6, 32'h8000_0000, 32'd0, 5'd4, 32'h0000_0000);
    op1("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
    op1("sub_neg", 4'd1, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
    op1("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0);
    op1("or", 4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFFF0_FFF0);
    op1("nor", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h000F_000F);
    op1("xor", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFF00_FF00);
    op1("op15", 4'd15, 32'h1234_5678, 32'h1, 5'd3, 32'h0000_0000);
    op1("mfhi_rst", 4'd12, 32'd0, 32'd0, 5'd0, 32'h0000_0000);

    issue(4'd10, 32'hFFFF_FFFD, 32'd5, 5'd0);
    wait_done(n, low);
    chk("mult_latency", 64'(n), 64'd32);
    chk("mult_ready_low", 64'(low), 64'd32);
    chk("mult_lo", 64'(result), 64'hFFFF_FFF1);
    op1("mult_mfhi", 4'd12, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    op1("mult_mflo", 4'd13, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFF1);

    issue(4'd10, 32'h8000_0000, 32'h8000_0000, 5'd0);
    wait_done(n, low);
    chk("mult_minneg_lo", 64'(result), 64'h0);
    op1("mult_minneg_hi", 4'd12, 32'd0, 32'd0, 5'd0, 32'h4000_0000);

    issue(4'd9, 32'hFFFF_FFFF, 32'd2, 5'd0);
    wait_done(n, low);
    chk("multu_lo", 64'(result), 64'hFFFF_FFFE);
    op1("multu_hi", 4'd12, 32'd0, 32'd0, 5'd0, 32'h0000_0001);

    issue(4'd11, 32'd100, 32'd7, 5'd0);
    wait_done(n, low);
    chk("divu_q", 64'(result), 64'd14);
    chk("divu_dbz", 64'(div_by_zero), 64'd0);
    op1("divu_r", 4'd12, 32'd0, 32'd0, 5'd0, 32'd2);

    issue(4'd11, 32'h1234, 32'd0, 5'd0);
    wait_done(n, low);
    chk("div0_latency", 64'(n), 64'd32);
    chk("div0_q", 64'(result), 64'hFFFF_FFFF);
    chk("div0_dbz", 64'(div_by_zero), 64'd1);
    op1("div0_r", 4'd12, 32'd0, 32'd0, 5'd0, 32'h1234);

    issue(4'd9, 32'd3, 32'd4, 5'd0);
    wait_done(n, low);
    chk("pre_lo", 64'(result), 64'd12);
    issue(4'd11, 32'd100, 32'd7, 5'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_no_valid", 64'(out_valid), 64'd0);
    p0 = pulses;
    repeat (40) @(negedge clk);
    chk("flush_no_pulse", 64'(pulses - p0), 64'd0);
    op1("flush_lo", 4'd13, 32'd0, 32'd0, 5'd0, 32'd12);
    op1("flush_hi", 4'd12, 32'd0, 32'd0, 5'd0, 32'd0);
    op1("flush_add", 4'd0, 32'd1, 32'd2, 5'd0, 32'd3);

    flush = 1'b1; cmd = 4'd0; val1 = 32'd9; val2 = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_drop", 64'(out_valid), 64'd0);

    issue(4'd10, 32'd7, 32'd9, 5'd0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    op1("arst_hi", 4'd12, 32'd0, 32'd0, 5'd0, 32'd0);
    op1("arst_lo", 4'd13, 32'd0, 32'd0, 5'd0, 32'd0);
    op1("arst_add", 4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle execute-stage ALU for the pipeline. Single-cycle ops (add/sub/logic/shift) return a registered result one cycle after acceptance. Iterative multiply (signed and unsigned) and unsigned divide run for WIDTH cycles and write the internal HI/LO registers. A valid/ready handshake lets the pipeline stall while the unit is busy.

## Interface
- `WIDTH`, default 32: operand, result, HI and LO width. Must be a power of two, at least 8.
- `SHAMT_W`, default $clog2(WIDTH): shift-amount width.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: command present.
- `in_ready` output 1: unit can accept a command. High iff FSM is in IDLE.
- `cmd` input 4: operation code (see Operation).
- `val1` input WIDTH: operand A (dividend, shift source).
- `val2` input WIDTH: operand B (divisor).
- `shamt` input SHAMT_W: shift amount for SLL/SRL/SRA.
- `flush` input 1: synchronous abort of any in-flight op.
- `out_valid` output 1: one-cycle pulse; `result` is valid.
- `result` output WIDTH: registered result.
- `div_by_zero` output 1: pulses with `out_valid` for a DIVU whose divisor is 0.
- `busy` output 1: high while in MUL or DIV state.

## Operation
- **Acceptance.** A command is accepted on an edge where `in_valid && in_ready && !flush`.
- **Opcodes:**
  - 0 ADD, 1 SUB: modulo 2^WIDTH.
  - 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLL: `val1` << `shamt`.
  - 7 SRL: logical right, zero fill.
  - 8 SRA: arithmetic right, sign fill.
  - 9 MULTU, 10 MULT: the 2·WIDTH-bit product goes to {HI,LO}.
  - 11 DIVU: LO = quotient, HI = remainder.
  - 12 MFHI: result = HI. 13 MFLO: result = LO.
  - 14, 15: result = 0, no other effect.
- **FSM states:** IDLE, MUL, DIV.
  - IDLE → MUL on accepted 9/10. IDLE → DIV on accepted 11. Every other accepted op stays in IDLE.
  - MUL/DIV → IDLE when the iteration counter reaches WIDTH, or on `flush`.
- **Multiply.** Radix-2 shift-add over WIDTH iterations on operand magnitudes. For MULT, the full 2·WIDTH product is two's-complement negated if the operand signs differ. MULT of the most-negative value uses its WIDTH-bit unsigned magnitude (2^(WIDTH-1)) and is exact.
- **Divide.** Restoring division, one quotient bit per iteration, MSB first.
  - Divisor 0: LO = all ones, HI = `val1`, `div_by_zero` = 1. Still takes WIDTH cycles.
- **Multi-cycle completion.** On completion, HI and LO update and `result` = new LO.
- **Register effects.** Single-cycle ops never modify HI/LO.
- **Flush.**
  - In IDLE: a command presented in the same cycle is not accepted.
  - In MUL/DIV: return to IDLE on the next edge. HI/LO are unchanged, no `out_valid`, no `div_by_zero`.

## Timing
- **Reset values:** `out_valid` 0, `result` 0, `div_by_zero` 0, `busy` 0, HI 0, LO 0, state IDLE, so `in_ready` 1.
- **Single-cycle op** accepted at edge k: `result` and `out_valid` are registered at edge k; `out_valid` is high for exactly one cycle after edge k. Back-to-back ops give one result per cycle.
- **MULT/MULTU/DIVU** accepted at edge k:
  - `busy` = 1 and `in_ready` = 0 after edge k.
  - Iterations occur on edges k+1 … k+WIDTH.
  - After edge k+WIDTH: `out_valid` = 1 (one cycle), HI/LO updated, `busy` = 0, `in_ready` = 1.
  - A new command is accepted in that same cycle.
  - Total latency: WIDTH+1 edges from acceptance to visible result.
- **MFHI/MFLO** issued in the cycle `out_valid` pulses for a multiply/divide see the new HI/LO (that op is accepted on the edge after the update).
- **No backpressure on output.** The consumer must take `result` during the `out_valid` cycle.
- **`in_valid` while `in_ready` = 0:** ignored. The issuer must hold the command.
- **`rst` asserted mid-operation:** immediately forces all reset values asynchronously; the partial result is discarded.
- **`flush` and completion on the same edge:** flush wins; no `out_valid`, HI/LO unchanged.

## Test plan
- **Shifts,** WIDTH=32, `val1`=0x80000000, `shamt`=4: SRA → 0xF8000000, SRL → 0x08000000, SLL → 0x00000000. Each `out_valid` appears one cycle after acceptance.
- **Signed multiply:** MULT −3 × 5 → `out_valid` after 33 edges, HI=0xFFFFFFFF, LO=0xFFFFFFF1. `in_ready` is low for 32 cycles. A following MFHI returns 0xFFFFFFFF.
- **Unsigned multiply:** MULTU 0xFFFFFFFF × 2 → HI=0x00000001, LO=0xFFFFFFFE.
- **Divide:** DIVU 100 / 7 → LO=14, HI=2, `div_by_zero`=0. DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234, `div_by_zero` pulses with `out_valid`.
- **Flush:** start DIVU 100/7 with HI/LO preloaded (MULTU 3×4), then assert `flush` at iteration 10. Required: no `out_valid`, LO=12, HI=0, `in_ready`=1 next cycle, and the next ADD 1+2 → 3.
- **Reset mid-multiply:** drop `rst` at iteration 5 of a MULT. Required: outputs immediately at reset values, HI=LO=0. After release, ADD 0xFFFFFFFF+1 → 0x00000000.
